mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port (fetch/data) single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int STARVE_LIMIT_DEF = 4;
    // Wide enough for the largest legal limit (15).
    localparam int STARVE_CW        = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating fetch-starvation counter: counts lost fetch cycles, clears on a fetch grant,
// and flags when the limit is reached.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [STARVE_CW-1:0] cnt,
    output logic                 at_limit
);

    localparam logic [STARVE_CW-1:0] LIM = STARVE_CW'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory.
// Optional perf counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [AW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [AW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   i_stall_cnt,
`endif
    output owner_e        owner
);

    // Handshake: req is a valid that the requester holds (with addr/wdata) until gnt;
    // gnt is a combinational ready, and req&&gnt is the single transfer cycle. A req
    // dropped before gnt simply cancels.

    logic [STARVE_CW-1:0] starve_cnt;
    logic                 starve_hit;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (i_req && !i_gnt),
        .clr      (i_gnt),
        .cnt      (starve_cnt),
        .at_limit (starve_hit)
    );

    // Data port wins unless fetch has been starved up to the limit.
    always_comb begin
        d_gnt = rst_n && d_req && !(i_req && starve_hit);
        i_gnt = rst_n && i_req && !d_gnt;
    end

    always_comb begin
        mem_en    = i_gnt || d_gnt;
        mem_wen   = d_gnt && d_wen;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end
    end

    // Owner remembers who issued last cycle's read, so the 1-cycle memory response
    // is steered to it. Stores leave no owner and thus never produce d_rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else if (i_gnt) begin
            owner <= OWN_I;
        end else if (d_gnt && !d_wen) begin
            owner <= OWN_D;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign i_rvalid = (owner == OWN_I);
    assign d_rvalid = (owner == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            i_stall_cnt  <= '0;
        end else begin
            if (i_req && d_req) conflict_cnt <= conflict_cnt + 32'd1;
            if (i_req && !i_gnt) i_stall_cnt <= i_stall_cnt + 32'd1;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, starvation priority, read routing and reset.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [AW-1:0] i_rdata;
    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [AW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [AW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic [AW-1:0] mem_rdata;
    owner_e        owner;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   conflict_cnt;
    logic [31:0]   i_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [AW:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef MEM_ARB_PERF_CNT_EN
        .conflict_cnt (conflict_cnt),
        .i_stall_cnt  (i_stall_cnt),
`endif
        .owner     (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs checked #1 later
    task automatic idle();
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_wen     = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    int n_gnt;
    int n_rv;
    logic exp_i;
    logic prev_i;
    logic [AW:0] e;

    initial begin
        idle();
        mem_rdata = '0;
        rst_n     = 1'b0;
        @(negedge clk);

        // reset state, with requests present
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        check("rst_i_gnt", 32'(i_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        check("rst_owner", 32'(owner), 32'(OWN_NONE));
        idle();
        cyc();
        rst_n = 1'b1;
        cyc();

        // idle outputs
        #1;
        check("idle_mem", 32'({mem_en, mem_wen}), 32'd0);
        check("idle_addr", mem_addr, 32'd0);
        check("idle_wdata", mem_wdata, 32'd0);

        // single fetch read
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 32'h10;
        #1;
        check("f_i_gnt", 32'(i_gnt), 32'd1);
        check("f_mem_en", 32'(mem_en), 32'd1);
        check("f_mem_wen", 32'(mem_wen), 32'd0);
        check("f_mem_addr", mem_addr, 32'h10);
        cyc();
        idle();
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("f_i_rvalid", 32'(i_rvalid), 32'd1);
        check("f_i_rdata", i_rdata, 32'hDEADBEEF);
        check("f_d_rvalid", 32'(d_rvalid), 32'd0);

        // store
        @(negedge clk);
        d_req   = 1'b1;
        d_wen   = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h55;
        #1;
        check("s_d_gnt", 32'(d_gnt), 32'd1);
        check("s_mem_en_wen", 32'({mem_en, mem_wen}), 32'd3);
        check("s_mem_addr", mem_addr, 32'h20);
        check("s_mem_wdata", mem_wdata, 32'h55);
        cyc();
        idle();
        #1;
        check("s_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);

        // contention: data wins 4 cycles, starved fetch wins cycle 4, data wins cycle 5
        @(negedge clk);
        prev_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_req  = 1'b1;
            i_addr = 32'h100;
            d_req  = 1'b1;
            d_wen  = 1'b0;
            d_addr = 32'h200;
            exp_i  = (c == 4);
            #1;
            check($sformatf("c%0d_i_gnt", c), 32'(i_gnt), 32'(exp_i));
            check($sformatf("c%0d_d_gnt", c), 32'(d_gnt), 32'(!exp_i));
            check($sformatf("c%0d_addr", c), mem_addr, exp_i ? 32'h100 : 32'h200);
            if (c > 0) begin
                check($sformatf("c%0d_rv", c), 32'({i_rvalid, d_rvalid}), prev_i ? 32'd2 : 32'd1);
            end
            prev_i = exp_i;
            cyc();
        end
        idle();
        #1;
        check("c_last_rv", 32'({i_rvalid, d_rvalid}), 32'd1);

        // alternating fetch / load, responses scoreboarded
        do_reset();
        n_gnt = 0;
        n_rv  = 0;
        for (int c = 0; c < 9; c++) begin
            idle();
            mem_rdata = 32'hA000_0000 + 32'(c);
            if (c < 8) begin
                if (c % 2 == 0) begin
                    i_req  = 1'b1;
                    i_addr = 32'h40 + 32'(c);
                end else begin
                    d_req  = 1'b1;
                    d_addr = 32'h80 + 32'(c);
                end
            end
            #1;
            if (i_rvalid || d_rvalid) begin
                n_rv++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("alt%0d_rv", c), 32'({i_rvalid, d_rvalid}), e[AW] ? 32'd2 : 32'd1);
                    check($sformatf("alt%0d_rdata", c), e[AW] ? i_rdata : d_rdata, e[AW-1:0]);
                end
            end
            if (i_gnt || d_gnt) begin
                n_gnt++;
                exp_q.push_back({(c % 2 == 0), 32'hA000_0000 + 32'(c + 1)});
            end
            cyc();
        end
        check("alt_grants", 32'(n_gnt), 32'd8);
        check("alt_rvalids", 32'(n_rv), 32'd8);
        check("alt_q_empty", 32'(exp_q.size()), 32'd0);

        // reset with a fetch outstanding
        idle();
        i_req  = 1'b1;
        i_addr = 32'h30;
        #1;
        check("r_i_gnt", 32'(i_gnt), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        check("r_i_rvalid", 32'(i_rvalid), 32'd0);
        check("r_owner", 32'(owner), 32'(OWN_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1;
        check("r_post_rv", 32'({i_rvalid, d_rvalid}), 32'd0);

`ifdef MEM_ARB_PERF_CNT_EN
        do_reset();
        for (int c = 0; c < 10; c++) begin
            i_req = 1'b1;
            d_req = 1'b1;
            d_wen = 1'b0;
            #1;
            check($sformatf("p%0d_i_gnt", c), 32'(i_gnt), (c == 4 || c == 9) ? 32'd1 : 32'd0);
            cyc();
        end
        idle();
        #1;
        check("perf_conflict", conflict_cnt, 32'd10);
        check("perf_i_stall", i_stall_cnt, 32'd8);
`endif

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
